axi4lite_window_stats: RTL and testbench

//  Windowed AXI4-lite traffic statistics, fed by per-channel transfer/response pulses from axi4liteMonitor.

---
 rtl/axi4lite_window_stats.sv | 172 +++++++++++++++++
 tb/tb_axi4lite_window_stats.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_window_stats.sv
// Windowed AXI4-lite traffic statistics: per-window saturating transfer/error counts,
// live outstanding depth with per-window peak, and a sticky protocol error flag.

module axi4lite_window_sat_ctr #(
   parameter int CTR_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic             i_win_end,
   input  logic             i_ev,
   output logic [CTR_W-1:0] o_snap
);
   logic [CTR_W-1:0] acc, sum;

   assign sum = (i_ev && acc != '1) ? acc + 1'b1 : acc;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc    <= '0;
         o_snap <= '0;
      end else if (i_clear) begin
         acc <= '0;
      end else if (i_en) begin
         if (i_win_end) begin
            o_snap <= sum;
            acc    <= '0;
         end else begin
            acc <= sum;
         end
      end
   end
endmodule

module axi4lite_window_outstanding #(
   parameter int OUTSTANDING_W = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clear,
   input  logic                     i_win_end,
   input  logic                     i_inc,
   input  logic                     i_dec,
   output logic [OUTSTANDING_W-1:0] o_cnt,
   output logic [OUTSTANDING_W-1:0] o_peak,
   output logic                     o_err
);
   logic [OUTSTANDING_W-1:0] nxt, run_pk;

   // Over/underflow holds the counter and raises an error instead of wrapping.
   always_comb begin
      nxt   = o_cnt;
      o_err = 1'b0;
      if (i_inc && !i_dec) begin
         if (o_cnt == '1) o_err = 1'b1;
         else             nxt   = o_cnt + 1'b1;
      end else if (i_dec && !i_inc) begin
         if (o_cnt == '0) o_err = 1'b1;
         else             nxt   = o_cnt - 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_cnt  <= '0;
         o_peak <= '0;
         run_pk <= '0;
      end else begin
         o_cnt <= nxt;
         if (i_clear) begin
            run_pk <= nxt;
         end else if (i_win_end) begin
            o_peak <= (nxt > run_pk) ? nxt : run_pk;
            run_pk <= nxt;
         end else if (nxt > run_pk) begin
            run_pk <= nxt;
         end
      end
   end
endmodule

module axi4lite_window_stats #(
   parameter int CTR_W         = 16,
   parameter int WINDOW_LEN    = 1000,
   parameter int WINDOW_W      = 10,
   parameter int OUTSTANDING_W = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic                     i_clear,
   input  logic                     i_aw_tfr,
   input  logic                     i_w_tfr,
   input  logic                     i_b_tfr,
   input  logic                     i_ar_tfr,
   input  logic                     i_r_tfr,
   input  logic                     i_b_notokay,
   input  logic                     i_r_notokay,
   output logic                     o_window_done,
   output logic [CTR_W-1:0]         o_aw_cnt,
   output logic [CTR_W-1:0]         o_w_cnt,
   output logic [CTR_W-1:0]         o_b_cnt,
   output logic [CTR_W-1:0]         o_ar_cnt,
   output logic [CTR_W-1:0]         o_r_cnt,
   output logic [CTR_W-1:0]         o_b_err_cnt,
   output logic [CTR_W-1:0]         o_r_err_cnt,
   output logic [OUTSTANDING_W-1:0] o_wr_outstanding,
   output logic [OUTSTANDING_W-1:0] o_rd_outstanding,
   output logic [OUTSTANDING_W-1:0] o_wr_peak,
   output logic [OUTSTANDING_W-1:0] o_rd_peak,
   output logic                     o_protocol_err
);
   localparam int                  NCH  = 7;
   localparam logic [WINDOW_W-1:0] LAST = WINDOW_W'(WINDOW_LEN - 1);

   logic [WINDOW_W-1:0]         cyc;
   logic                        win_end, wr_err, rd_err;
   logic [NCH-1:0]              ev;
   logic [NCH-1:0][CTR_W-1:0]   snap;

   // Clear takes priority, so a clear on the last cycle suppresses the snapshot.
   assign win_end = i_en && !i_clear && (cyc == LAST);
   assign ev = {i_r_tfr & i_r_notokay, i_b_tfr & i_b_notokay,
                i_r_tfr, i_ar_tfr, i_b_tfr, i_w_tfr, i_aw_tfr};

   generate
      for (genvar g = 0; g < NCH; g++) begin : g_ch
         axi4lite_window_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
            .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_en(i_en),
            .i_win_end(win_end), .i_ev(ev[g]), .o_snap(snap[g])
         );
      end
   endgenerate

   assign o_aw_cnt    = snap[0];
   assign o_w_cnt     = snap[1];
   assign o_b_cnt     = snap[2];
   assign o_ar_cnt    = snap[3];
   assign o_r_cnt     = snap[4];
   assign o_b_err_cnt = snap[5];
   assign o_r_err_cnt = snap[6];

   axi4lite_window_outstanding #(.OUTSTANDING_W(OUTSTANDING_W)) u_wr (
      .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_win_end(win_end),
      .i_inc(i_aw_tfr), .i_dec(i_b_tfr),
      .o_cnt(o_wr_outstanding), .o_peak(o_wr_peak), .o_err(wr_err)
   );

   axi4lite_window_outstanding #(.OUTSTANDING_W(OUTSTANDING_W)) u_rd (
      .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_win_end(win_end),
      .i_inc(i_ar_tfr), .i_dec(i_r_tfr),
      .o_cnt(o_rd_outstanding), .o_peak(o_rd_peak), .o_err(rd_err)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cyc            <= '0;
         o_window_done  <= 1'b0;
         o_protocol_err <= 1'b0;
      end else begin
         o_window_done <= win_end;
         if (i_clear) begin
            cyc            <= '0;
            o_protocol_err <= 1'b0;
         end else begin
            if (i_en) cyc <= (cyc == LAST) ? '0 : cyc + 1'b1;
            if (wr_err || rd_err) o_protocol_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_axi4lite_window_stats.sv
// Self-checking bench for axi4lite_window_stats: directed windows plus randomized traffic
// compared every cycle against an arithmetic reference model.

module tb_axi4lite_window_stats;
   localparam int CW = 3, WL = 8, WW = 3, OW = 2;
   localparam int CMAX = (1 << CW) - 1, OMAX = (1 << OW) - 1;

   logic i_clk = 1'b0, i_rst = 1'b1, i_en = 1'b0, i_clear = 1'b0;
   logic i_aw_tfr = 0, i_w_tfr = 0, i_b_tfr = 0, i_ar_tfr = 0, i_r_tfr = 0;
   logic i_b_notokay = 0, i_r_notokay = 0;
   logic o_window_done, o_protocol_err;
   logic [CW-1:0] o_aw_cnt, o_w_cnt, o_b_cnt, o_ar_cnt, o_r_cnt, o_b_err_cnt, o_r_err_cnt;
   logic [OW-1:0] o_wr_outstanding, o_rd_outstanding, o_wr_peak, o_rd_peak;

   axi4lite_window_stats #(.CTR_W(CW), .WINDOW_LEN(WL), .WINDOW_W(WW), .OUTSTANDING_W(OW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_clear(i_clear),
      .i_aw_tfr(i_aw_tfr), .i_w_tfr(i_w_tfr), .i_b_tfr(i_b_tfr), .i_ar_tfr(i_ar_tfr),
      .i_r_tfr(i_r_tfr), .i_b_notokay(i_b_notokay), .i_r_notokay(i_r_notokay),
      .o_window_done(o_window_done), .o_aw_cnt(o_aw_cnt), .o_w_cnt(o_w_cnt),
      .o_b_cnt(o_b_cnt), .o_ar_cnt(o_ar_cnt), .o_r_cnt(o_r_cnt),
      .o_b_err_cnt(o_b_err_cnt), .o_r_err_cnt(o_r_err_cnt),
      .o_wr_outstanding(o_wr_outstanding), .o_rd_outstanding(o_rd_outstanding),
      .o_wr_peak(o_wr_peak), .o_rd_peak(o_rd_peak), .o_protocol_err(o_protocol_err)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0, n_fail = 0;

   // Reference model state: window position, per-channel tallies, depths and peaks.
   int m_cyc, m_acc[7], m_snap[7], m_out[2], m_pk[2], m_spk[2];
   int m_err, m_done;

   function automatic void model_reset();
      m_cyc = 0; m_err = 0; m_done = 0;
      for (int i = 0; i < 7; i++) begin m_acc[i] = 0; m_snap[i] = 0; end
      for (int k = 0; k < 2; k++) begin m_out[k] = 0; m_pk[k] = 0; m_spk[k] = 0; end
   endfunction

   function automatic void model_step(input bit aw, w, b, ar, r, bn, rn, en, clr);
      int ev[7];
      int inc[2], dec[2];
      bit bad = 0;
      ev[0] = aw; ev[1] = w; ev[2] = b; ev[3] = ar; ev[4] = r;
      ev[5] = b & bn; ev[6] = r & rn;
      inc[0] = aw; dec[0] = b; inc[1] = ar; dec[1] = r;
      for (int k = 0; k < 2; k++) begin
         if (inc[k] == 1 && dec[k] == 0) begin
            if (m_out[k] == OMAX) bad = 1; else m_out[k] += 1;
         end else if (dec[k] == 1 && inc[k] == 0) begin
            if (m_out[k] == 0) bad = 1; else m_out[k] -= 1;
         end
      end
      m_done = 0;
      if (clr) begin
         m_cyc = 0; m_err = 0;
         for (int i = 0; i < 7; i++) m_acc[i] = 0;
         for (int k = 0; k < 2; k++) m_pk[k] = m_out[k];
      end else begin
         if (bad) m_err = 1;
         for (int k = 0; k < 2; k++) if (m_out[k] > m_pk[k]) m_pk[k] = m_out[k];
         if (en) begin
            for (int i = 0; i < 7; i++) m_acc[i] = (m_acc[i] + ev[i] > CMAX) ? CMAX : m_acc[i] + ev[i];
            if (m_cyc == WL - 1) begin
               for (int i = 0; i < 7; i++) begin m_snap[i] = m_acc[i]; m_acc[i] = 0; end
               for (int k = 0; k < 2; k++) begin m_spk[k] = m_pk[k]; m_pk[k] = m_out[k]; end
               m_cyc = 0; m_done = 1;
            end else m_cyc += 1;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("window_done", 32'(o_window_done), m_done);
      chk("aw_cnt", 32'(o_aw_cnt), m_snap[0]);
      chk("w_cnt", 32'(o_w_cnt), m_snap[1]);
      chk("b_cnt", 32'(o_b_cnt), m_snap[2]);
      chk("ar_cnt", 32'(o_ar_cnt), m_snap[3]);
      chk("r_cnt", 32'(o_r_cnt), m_snap[4]);
      chk("b_err_cnt", 32'(o_b_err_cnt), m_snap[5]);
      chk("r_err_cnt", 32'(o_r_err_cnt), m_snap[6]);
      chk("wr_outstanding", 32'(o_wr_outstanding), m_out[0]);
      chk("rd_outstanding", 32'(o_rd_outstanding), m_out[1]);
      chk("wr_peak", 32'(o_wr_peak), m_spk[0]);
      chk("rd_peak", 32'(o_rd_peak), m_spk[1]);
      chk("protocol_err", 32'(o_protocol_err), m_err);
   endtask

   task automatic drive(input bit aw, w, b, ar, r, bn, rn, en, clr);
      i_aw_tfr = aw; i_w_tfr = w; i_b_tfr = b; i_ar_tfr = ar; i_r_tfr = r;
      i_b_notokay = bn; i_r_notokay = rn; i_en = en; i_clear = clr;
      @(posedge i_clk);
      model_step(aw, w, b, ar, r, bn, rn, en, clr);
      #1 check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   // Reset pulse between clock edges: outputs must drop without waiting for a clock.
   task automatic reset_mid();
      #1 i_rst = 1'b1;
      #1 model_reset();
      check_all();
      #2 i_rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #2 check_all();
      #10 i_rst = 1'b0;

      // Full window of AW on every cycle: saturates at 7, depth pinned at 3 with an error.
      for (int i = 0; i < WL; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("dir_done_at_8", 32'(o_window_done), 1);
      chk("dir_aw_sat", 32'(o_aw_cnt), CMAX);
      chk("dir_w_zero", 32'(o_w_cnt), 0);
      chk("dir_wr_max", 32'(o_wr_outstanding), OMAX);
      chk("dir_aw_overflow_err", 32'(o_protocol_err), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("dir_done_one_cycle", 32'(o_window_done), 0);

      // Clear: error drops, live depth kept, fresh 8-cycle window with no pulse.
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("dir_clear_err", 32'(o_protocol_err), 0);
      chk("dir_clear_keeps_depth", 32'(o_wr_outstanding), OMAX);
      drive(0, 0, 1, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 1, 0, 0, 1, 0, 1, 0);
      chk("dir_b_underflow_depth", 32'(o_wr_outstanding), 0);
      chk("dir_b_underflow_err", 32'(o_protocol_err), 1);
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(1, 0, 1, 0, 0, 0, 0, 1, 0);
      chk("dir_aw_b_same_cycle", 32'(o_wr_outstanding), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("dir_window_after_clear", 32'(o_window_done), 1);
      chk("dir_b_cnt", 32'(o_b_cnt), 5);
      chk("dir_b_err_cnt", 32'(o_b_err_cnt), 1);

      // Enable low for 5 cycles mid-window delays the pulse; clear mid-window restarts it.
      idle(3);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
      idle(4);
      drive(0, 0, 0, 0, 1, 0, 1, 1, 0);
      chk("dir_en_gap_done", 32'(o_window_done), 1);
      chk("dir_en_gap_ar_uncounted", 32'(o_ar_cnt), 0);
      idle(4);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(7);
      chk("dir_no_pulse_after_clear", 32'(o_window_done), 0);
      idle(1);
      chk("dir_new_window_pulse", 32'(o_window_done), 1);

      // Randomized traffic with shifting intensities, sparse clears, one mid-run reset.
      for (int phase = 0; phase < 8; phase++) begin
         int pa, pb, pe, pc;
         pa = $urandom_range(10, 90); pb = $urandom_range(10, 90);
         pe = $urandom_range(60, 100); pc = $urandom_range(0, 4);
         for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 99) < pa, $urandom_range(0, 99) < pa,
                  $urandom_range(0, 99) < pb, $urandom_range(0, 99) < pa,
                  $urandom_range(0, 99) < pb, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 99) < pe,
                  $urandom_range(0, 99) < pc);
         end
         if (phase == 4) reset_mid();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
